// File: rtl/kia_tx_pkg.sv
// Shared register map, status bit positions and FSM encodings for the KIA PS/2 blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package kia_tx_pkg;

  // Register select values on ADR_I
  localparam logic KTSTAT = 1'b0;
  localparam logic KTDATA = 1'b1;

  // KTSTAT bit positions
  localparam int STAT_BUSY = 0;
  localparam int STAT_NAK  = 1;
  localparam int STAT_TMO  = 2;
  localparam int STAT_OVR  = 3;

  // Transmit FSM states; encodings are shared with the receiver side
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INHIBIT = 3'd1,
    S_SEND    = 3'd2,
    S_ACKW    = 3'd3,
    S_RECOV   = 3'd4
  } kt_state_t;

  // PS/2 parity bit: makes the total count of ones across data and parity odd
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/kia_tx_ps2_sync_edge.sv
// Two-flop synchronizer for the PS/2 clock and data pins plus a clock falling-edge pulse.
// Latency: sync outputs lag the pins by 2 cycles; c_fall is high 2 cycles after the pin falls.
// Backpressure: none; free-running sampler.
module ps2_sync_edge (
  input  logic CLK_I,
  input  logic RES_I,
  input  logic c_pin,
  input  logic d_pin,
  output logic c_sync,
  output logic d_sync,
  output logic c_fall
);

  logic [1:0] c_ff;
  logic [1:0] d_ff;
  logic       c_prev;

  // Synchronizer chain; resets to the idle-high line level so reset never fakes a fall
  always_ff @(posedge CLK_I) begin
    if (RES_I) begin
      c_ff   <= 2'b11;
      d_ff   <= 2'b11;
      c_prev <= 1'b1;
    end else begin
      c_ff   <= {c_ff[0], c_pin};
      d_ff   <= {d_ff[0], d_pin};
      c_prev <= c_ff[1];
    end
  end

  assign c_sync = c_ff[1];
  assign d_sync = d_ff[1];
  assign c_fall = c_prev & ~c_ff[1];

endmodule

// File: rtl/kia_tx.sv
// PS/2 host-to-device transmitter with a two-register Wishbone slave (KTSTAT, KTDATA).
// Latency: bus ACK one cycle after CYC&STB; frame starts after INHIBIT_CYCLES of clock inhibit.
// Backpressure: none on the bus; a KTDATA write while busy is dropped and flagged as OVR.
module kia_tx
  import kia_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       CLK_I,
  input  logic       RES_I,
  input  logic       ADR_I,
  input  logic       WE_I,
  input  logic       CYC_I,
  input  logic       STB_I,
  input  logic [7:0] DAT_I,
  output logic       ACK_O,
  output logic [7:0] DAT_O,
  input  logic       C_I,
  input  logic       D_I,
  output logic       C_OE,
  output logic       D_OE
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Bus request captured alongside ACK_O so the access acts in the ACK cycle
  logic       req_adr;
  logic       req_we;
  logic [7:0] req_dat;

  kt_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       bit_cnt;
  logic [7:0]       last_byte;
  logic             parity_q;
  logic             nak;
  logic             tmo;
  logic             ovr;

  logic       c_sync;
  logic       d_sync;
  logic       c_fall;
  logic       busy;
  logic       wr_stat;
  logic       wr_data;
  logic       in_frame;
  logic [8:0] frame;
  logic [7:0] status;

  ps2_sync_edge u_sync (
    .CLK_I  (CLK_I),
    .RES_I  (RES_I),
    .c_pin  (C_I),
    .d_pin  (D_I),
    .c_sync (c_sync),
    .d_sync (d_sync),
    .c_fall (c_fall)
  );

  assign busy     = (state != S_IDLE);
  assign wr_stat  = ACK_O & req_we & (req_adr == KTSTAT);
  assign wr_data  = ACK_O & req_we & (req_adr == KTDATA);
  assign in_frame = (state == S_SEND) || (state == S_ACKW) || (state == S_RECOV);
  assign frame    = {parity_q, last_byte};

  // Single-cycle bus turnaround: acknowledge whatever was strobed last cycle
  always_ff @(posedge CLK_I) begin
    if (RES_I) begin
      ACK_O   <= 1'b0;
      req_adr <= 1'b0;
      req_we  <= 1'b0;
      req_dat <= 8'h00;
    end else begin
      ACK_O   <= CYC_I & STB_I;
      req_adr <= ADR_I;
      req_we  <= WE_I;
      req_dat <= DAT_I;
    end
  end

  // Read mux; data bus is quiet whenever no acknowledge is being given
  always_comb begin
    status            = 8'h00;
    status[STAT_BUSY] = busy;
    status[STAT_NAK]  = nak;
    status[STAT_TMO]  = tmo;
    status[STAT_OVR]  = ovr;
    DAT_O             = 8'h00;
    if (ACK_O) DAT_O = (req_adr == KTDATA) ? last_byte : status;
  end

  // Transmit FSM with registered line enables; flag sets are written after the clear so they win
  always_ff @(posedge CLK_I) begin
    if (RES_I) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_cnt   <= 4'd0;
      last_byte <= 8'h00;
      parity_q  <= 1'b0;
      nak       <= 1'b0;
      tmo       <= 1'b0;
      ovr       <= 1'b0;
      C_OE      <= 1'b0;
      D_OE      <= 1'b0;
    end else begin
      if (wr_stat) begin
        nak <= 1'b0;
        tmo <= 1'b0;
        ovr <= 1'b0;
      end

      if (wr_data && busy) ovr <= 1'b1;

      if (in_frame && (cnt == TMO_LAST)) begin
        // Device stopped responding: let go of both lines and give up on the frame
        C_OE  <= 1'b0;
        D_OE  <= 1'b0;
        tmo   <= 1'b1;
        state <= S_IDLE;
      end else begin
        if (in_frame && (cnt != CNT_MAX)) cnt <= cnt + CNT_W'(1);

        case (state)
          S_IDLE: begin
            C_OE <= 1'b0;
            D_OE <= 1'b0;
            if (wr_data) begin
              last_byte <= req_dat;
              parity_q  <= odd_parity(req_dat);
              bit_cnt   <= 4'd0;
              cnt       <= '0;
              C_OE      <= 1'b1;
              state     <= S_INHIBIT;
            end
          end

          S_INHIBIT: begin
            if (cnt == INH_LAST) begin
              // Release the clock with data low: request-to-send / start bit
              C_OE    <= 1'b0;
              D_OE    <= 1'b1;
              cnt     <= '0;
              bit_cnt <= 4'd0;
              state   <= S_SEND;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end

          S_SEND: begin
            if (c_fall) begin
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd9) begin
                D_OE  <= 1'b0;
                state <= S_ACKW;
              end else begin
                D_OE <= ~frame[bit_cnt];
              end
            end
          end

          S_ACKW: begin
            if (c_fall) begin
              if (d_sync) nak <= 1'b1;
              state <= S_RECOV;
            end
          end

          S_RECOV: begin
            if (c_sync && d_sync) state <= S_IDLE;
          end

          default: begin
            C_OE  <= 1'b0;
            D_OE  <= 1'b0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_kia_tx.sv
// Bench for kia_tx: Wishbone master tasks plus a behavioural PS/2 device that clocks frames in.
// Expected wire bits are queued when a byte is written and popped as the device samples them.
module tb_kia_tx;

  logic       CLK_I = 1'b0;
  logic       RES_I = 1'b1;
  logic       ADR_I = 1'b0;
  logic       WE_I  = 1'b0;
  logic       CYC_I = 1'b0;
  logic       STB_I = 1'b0;
  logic [7:0] DAT_I = 8'h00;
  logic       ACK_O;
  logic [7:0] DAT_O;
  logic       C_OE;
  logic       D_OE;

  logic model_c_low = 1'b0;
  logic model_d_low = 1'b0;
  logic c_line;
  logic d_line;

  int checks   = 0;
  int failures = 0;
  logic exp_q[$];

  assign c_line = ~(C_OE | model_c_low);
  assign d_line = ~(D_OE | model_d_low);

  always #5 CLK_I = ~CLK_I;

  kia_tx #(
    .INHIBIT_CYCLES (10),
    .TIMEOUT_CYCLES (400)
  ) dut (
    .CLK_I (CLK_I),
    .RES_I (RES_I),
    .ADR_I (ADR_I),
    .WE_I  (WE_I),
    .CYC_I (CYC_I),
    .STB_I (STB_I),
    .DAT_I (DAT_I),
    .ACK_O (ACK_O),
    .DAT_O (DAT_O),
    .C_I   (c_line),
    .D_I   (d_line),
    .C_OE  (C_OE),
    .D_OE  (D_OE)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wb_write(input logic adr, input logic [7:0] dat);
    @(negedge CLK_I);
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; ADR_I = adr; DAT_I = dat;
    @(negedge CLK_I);
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
  endtask

  task automatic wb_read(input logic adr, output logic [7:0] dat, output logic ack);
    @(negedge CLK_I);
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; ADR_I = adr;
    @(negedge CLK_I);
    ack = ACK_O;
    dat = DAT_O;
    CYC_I = 1'b0; STB_I = 1'b0;
  endtask

  // Expected wire sequence: start 0, data LSB first, odd parity, stop 1
  task automatic push_frame(input logic [7:0] b);
    logic p;
    p = 1'b1;
    for (int i = 0; i < 8; i++) if (b[i]) p = ~p;
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
    exp_q.push_back(p);
    exp_q.push_back(1'b1);
  endtask

  // Device model: waits for request-to-send, generates clocks at a 20-cycle period,
  // samples data on each rising edge; stop_fall>0 returns with the clock held low at that fall
  task automatic device(input logic do_ack, input int stop_fall, output logic done);
    int w;
    logic b, e;
    done = 1'b0;
    w = 0;
    while (!(C_OE === 1'b0 && D_OE === 1'b1) && w < 200) begin
      @(negedge CLK_I);
      w++;
    end
    checks++;
    if (w >= 200) begin
      failures++;
      $display("FAIL rts_wait: C_OE=%b D_OE=%b, required C_OE=0 D_OE=1 within 200 cycles", C_OE, D_OE);
      return;
    end
    repeat (5) @(negedge CLK_I);
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) begin
        model_c_low = 1'b1;
        repeat (10) @(negedge CLK_I);
        if (k == stop_fall) return;
        model_c_low = 1'b0;
        repeat (10) @(negedge CLK_I);
      end
      b = d_line;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL frame_bit%0d: got %b, no bit expected", k, b);
      end else begin
        e = exp_q.pop_front();
        if (b !== e) begin
          failures++;
          $display("FAIL frame_bit%0d: got %b, required %b", k, b, e);
        end
      end
    end
    if (do_ack) model_d_low = 1'b1;
    repeat (5) @(negedge CLK_I);
    model_c_low = 1'b1;
    repeat (10) @(negedge CLK_I);
    model_c_low = 1'b0;
    repeat (5) @(negedge CLK_I);
    model_d_low = 1'b0;
    repeat (10) @(negedge CLK_I);
    done = 1'b1;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    logic a;
    RES_I = 1'b1;
    repeat (3) @(posedge CLK_I);
    @(negedge CLK_I);
    checks++;
    if (C_OE !== 1'b0 || D_OE !== 1'b0) begin
      failures++;
      $display("FAIL reset_lines: C_OE=%b D_OE=%b, required 0 0", C_OE, D_OE);
    end
    checks++;
    if (ACK_O !== 1'b0 || DAT_O !== 8'h00) begin
      failures++;
      $display("FAIL reset_bus: ACK_O=%b DAT_O=%h, required 0 00", ACK_O, DAT_O);
    end
    RES_I = 1'b0;
    wb_read(1'b0, d, a);
    checks++;
    if (a !== 1'b1 || d !== 8'h00) begin
      failures++;
      $display("FAIL reset_ktstat: ack=%b data=%h, required 1 00", a, d);
    end
    wb_read(1'b1, d, a);
    checks++;
    if (d !== 8'h00) begin
      failures++;
      $display("FAIL reset_ktdata: got %h, required 00", d);
    end
  endtask

  task automatic test_send_ack;
    logic [7:0] d;
    logic a, done;
    int n;
    push_frame(8'hED);
    wb_write(1'b1, 8'hED);
    @(negedge CLK_I);
    n = 0;
    while (C_OE === 1'b1 && n < 100) begin
      n++;
      @(negedge CLK_I);
    end
    checks++;
    if (n !== 10 || D_OE !== 1'b1) begin
      failures++;
      $display("FAIL inhibit_len: C_OE low-pull %0d cycles D_OE=%b, required 10 cycles then 1", n, D_OE);
    end
    wb_read(1'b0, d, a);
    checks++;
    if (d !== 8'h01) begin
      failures++;
      $display("FAIL busy_stat: got %h, required 01", d);
    end
    device(1'b1, 0, done);
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL ed_frame_done: got %b, required 1", done);
    end
    repeat (20) @(negedge CLK_I);
    wb_read(1'b0, d, a);
    checks++;
    if (d !== 8'h00) begin
      failures++;
      $display("FAIL ed_done_stat: got %h, required 00", d);
    end
    wb_read(1'b1, d, a);
    checks++;
    if (d !== 8'hED) begin
      failures++;
      $display("FAIL ed_ktdata: got %h, required ED", d);
    end
  endtask

  task automatic test_nak;
    logic [7:0] d;
    logic a, done;
    push_frame(8'hF4);
    wb_write(1'b1, 8'hF4);
    device(1'b0, 0, done);
    repeat (20) @(negedge CLK_I);
    wb_read(1'b0, d, a);
    checks++;
    if (d !== 8'h02) begin
      failures++;
      $display("FAIL nak_stat: got %h, required 02", d);
    end
    wb_write(1'b0, 8'hFF);
    wb_read(1'b0, d, a);
    checks++;
    if (d !== 8'h00) begin
      failures++;
      $display("FAIL nak_clear: got %h, required 00", d);
    end
  endtask

  task automatic test_timeout;
    logic [7:0] d;
    logic a;
    int w, n;
    wb_write(1'b1, 8'hAA);
    w = 0;
    while (D_OE !== 1'b1 && w < 100) begin
      @(negedge CLK_I);
      w++;
    end
    n = 0;
    while (D_OE === 1'b1 && n < 1000) begin
      n++;
      @(negedge CLK_I);
    end
    checks++;
    if (n !== 400 || C_OE !== 1'b0) begin
      failures++;
      $display("FAIL timeout_len: released after %0d cycles C_OE=%b, required 400 and 0", n, C_OE);
    end
    wb_read(1'b0, d, a);
    checks++;
    if (d !== 8'h04) begin
      failures++;
      $display("FAIL tmo_stat: got %h, required 04", d);
    end
    wb_read(1'b1, d, a);
    checks++;
    if (d !== 8'hAA) begin
      failures++;
      $display("FAIL tmo_ktdata: got %h, required AA", d);
    end
    wb_write(1'b0, 8'h00);
    wb_read(1'b0, d, a);
    checks++;
    if (d !== 8'h00) begin
      failures++;
      $display("FAIL tmo_clear: got %h, required 00", d);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] d;
    logic a, done;
    push_frame(8'h55);
    wb_write(1'b1, 8'h55);
    wb_write(1'b1, 8'h66);
    device(1'b1, 0, done);
    repeat (20) @(negedge CLK_I);
    wb_read(1'b0, d, a);
    checks++;
    if (d !== 8'h08) begin
      failures++;
      $display("FAIL ovr_stat: got %h, required 08", d);
    end
    wb_read(1'b1, d, a);
    checks++;
    if (d !== 8'h55) begin
      failures++;
      $display("FAIL ovr_ktdata: got %h, required 55", d);
    end
    checks++;
    if (C_OE !== 1'b0 || D_OE !== 1'b0) begin
      failures++;
      $display("FAIL ovr_idle_lines: C_OE=%b D_OE=%b, required 0 0", C_OE, D_OE);
    end
    wb_write(1'b0, 8'h00);
  endtask

  task automatic test_reset_midframe;
    logic [7:0] d;
    logic a, done;
    // bit 4 is 0, so the data line is being pulled low when reset hits at fall 5
    push_frame(8'h0F);
    wb_write(1'b1, 8'h0F);
    device(1'b1, 5, done);
    exp_q.delete();
    RES_I = 1'b1;
    @(negedge CLK_I);
    checks++;
    if (C_OE !== 1'b0 || D_OE !== 1'b0) begin
      failures++;
      $display("FAIL midreset_lines: C_OE=%b D_OE=%b, required 0 0", C_OE, D_OE);
    end
    model_c_low = 1'b0;
    RES_I = 1'b0;
    repeat (3) @(negedge CLK_I);
    wb_read(1'b0, d, a);
    checks++;
    if (d !== 8'h00) begin
      failures++;
      $display("FAIL midreset_stat: got %h, required 00", d);
    end
    wb_read(1'b1, d, a);
    checks++;
    if (d !== 8'h00) begin
      failures++;
      $display("FAIL midreset_ktdata: got %h, required 00", d);
    end
    push_frame(8'h3C);
    wb_write(1'b1, 8'h3C);
    device(1'b1, 0, done);
    repeat (20) @(negedge CLK_I);
    wb_read(1'b0, d, a);
    checks++;
    if (done !== 1'b1 || d !== 8'h00) begin
      failures++;
      $display("FAIL fresh_frame: done=%b stat=%h, required 1 00", done, d);
    end
    wb_read(1'b1, d, a);
    checks++;
    if (d !== 8'h3C) begin
      failures++;
      $display("FAIL fresh_ktdata: got %h, required 3C", d);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d bits left, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_send_ack();
    test_nak();
    test_timeout();
    test_back_to_back();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
